// File: rtl/video_mnist_seg_hist_pkg.sv
// Shared constants for the MNIST segmentation class histogram.
// Register map, core identifier and FSM encoding.
package video_mnist_seg_hist_pkg;

  localparam logic [31:0] CORE_ID = 32'h527A_5E61;

  localparam int ADR_CORE_ID     = 'h00;
  localparam int ADR_CTL         = 'h04;
  localparam int ADR_STATUS      = 'h05;
  localparam int ADR_FRAME_COUNT = 'h06;
  localparam int ADR_PARAM_TH    = 'h07;
  localparam int ADR_ERR_COUNT   = 'h08;
  localparam int ADR_RESULT      = 'h10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/video_mnist_seg_hist_counter.sv
// Bank of saturating per-class counters.
// clear restarts the bank, keeping only the beat presented with it.
module video_mnist_seg_hist_counter #(
  parameter int NUM_CLASS   = 11,
  parameter int IDX_WIDTH   = 4,
  parameter int COUNT_WIDTH = 20
) (
  input  logic                             clk,
  input  logic                             wb_rst_i,
  input  logic                             clear,
  input  logic                             inc,
  input  logic [IDX_WIDTH-1:0]             index,
  output logic [NUM_CLASS*COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  logic [COUNT_WIDTH-1:0] cnt [NUM_CLASS];

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int k = 0; k < NUM_CLASS; k++)
        cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CLASS; k++) begin
        if (clear)
          cnt[k] <= (inc && index == IDX_WIDTH'(k))
                    ? COUNT_WIDTH'(1) : '0;
        else if (inc && index == IDX_WIDTH'(k)
                 && cnt[k] != CNT_MAX)
          cnt[k] <= cnt[k] + COUNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_flat
    assign count[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt[g];
  end

endmodule

// File: rtl/video_mnist_seg_hist.sv
// Per-frame class histogram of an MNIST segmentation stream.
// Stream passes straight through; results are read over Wishbone.
module video_mnist_seg_hist
  import video_mnist_seg_hist_pkg::*;
#(
  parameter int         NUM_CLASS     = 11,
  parameter int         TNUMBER_WIDTH = 4,
  parameter int         TCOUNT_WIDTH  = 4,
  parameter int         COUNT_WIDTH   = 20,
  parameter int         WB_ADR_WIDTH  = 8,
  parameter int         WB_DAT_WIDTH  = 32,
  parameter int         WB_SEL_WIDTH  = WB_DAT_WIDTH / 8,
  parameter logic [1:0] INIT_CTL      = 2'b01,
  parameter int         INIT_PARAM_TH = 1
) (
  input  logic                     clk,
  input  logic                     wb_rst_i,

  input  logic                     s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,

  output logic                     m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tnumber,
  output logic [TCOUNT_WIDTH-1:0]  m_axi4s_tcount,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,

  input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
  input  logic                     s_wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
  input  logic                     s_wb_stb_i,
  output logic                     s_wb_ack_o,

  output logic                     irq
);

  localparam logic [TNUMBER_WIDTH:0] NCLS =
    (TNUMBER_WIDTH+1)'(NUM_CLASS);

  assign m_axi4s_tuser   = s_axi4s_tuser;
  assign m_axi4s_tlast   = s_axi4s_tlast;
  assign m_axi4s_tnumber = s_axi4s_tnumber;
  assign m_axi4s_tcount  = s_axi4s_tcount;
  assign m_axi4s_tvalid  = s_axi4s_tvalid;
  assign s_axi4s_tready  = m_axi4s_tready;
  assign s_wb_ack_o      = s_wb_stb_i;

  state_t                       state, state_nxt;
  logic [1:0]                   ctl;
  logic [TCOUNT_WIDTH-1:0]      param_th;
  logic                         frame_done;
  logic [31:0]                  frame_count;
  logic [15:0]                  err_count;
  logic [COUNT_WIDTH-1:0]       result [NUM_CLASS];
  logic [NUM_CLASS*COUNT_WIDTH-1:0] work_cnt;

  logic accept, cls_ok, qual;
  logic start, publish, run_cnt;
  logic wr, wr_b0;

  assign accept = s_axi4s_tvalid & m_axi4s_tready;
  assign cls_ok = {1'b0, s_axi4s_tnumber} < NCLS;
  assign qual   = cls_ok & (s_axi4s_tcount >= param_th);
  assign wr     = s_wb_stb_i & s_wb_we_i;
  assign wr_b0  = wr & s_wb_sel_i[0];

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    publish   = 1'b0;
    run_cnt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ctl[0] && accept && s_axi4s_tuser) begin
          start     = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // disabled mid-frame: drop it, RESULT keeps the last full frame
        if (!ctl[0]) begin
          state_nxt = ST_IDLE;
        end else if (accept) begin
          if (s_axi4s_tuser) begin
            start   = 1'b1;
            publish = 1'b1;
          end else begin
            run_cnt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  video_mnist_seg_hist_counter #(
    .NUM_CLASS   (NUM_CLASS),
    .IDX_WIDTH   (TNUMBER_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_counter (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .clear    (start),
    .inc      ((start | run_cnt) & qual),
    .index    (s_axi4s_tnumber),
    .count    (work_cnt)
  );

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ctl      <= INIT_CTL;
      param_th <= TCOUNT_WIDTH'(INIT_PARAM_TH);
    end else if (wr_b0) begin
      if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL))
        ctl <= s_wb_dat_i[1:0];
      if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_TH))
        param_th <= s_wb_dat_i[TCOUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
      irq         <= 1'b0;
      for (int k = 0; k < NUM_CLASS; k++)
        result[k] <= '0;
    end else begin
      irq <= frame_done & ctl[1];
      if (publish) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 32'd1;
        for (int k = 0; k < NUM_CLASS; k++)
          result[k] <= work_cnt[k*COUNT_WIDTH +: COUNT_WIDTH];
      end else if (wr && s_wb_adr_i == WB_ADR_WIDTH'(ADR_STATUS)) begin
        frame_done <= 1'b0;
      end
      if (accept && !cls_ok && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

  always_comb begin
    s_wb_dat_o = '0;
    unique case (1'b1)
      s_wb_adr_i == WB_ADR_WIDTH'(ADR_CORE_ID):
        s_wb_dat_o = WB_DAT_WIDTH'(CORE_ID);
      s_wb_adr_i == WB_ADR_WIDTH'(ADR_CTL):
        s_wb_dat_o = WB_DAT_WIDTH'(ctl);
      s_wb_adr_i == WB_ADR_WIDTH'(ADR_STATUS):
        s_wb_dat_o = WB_DAT_WIDTH'({state == ST_RUN, frame_done});
      s_wb_adr_i == WB_ADR_WIDTH'(ADR_FRAME_COUNT):
        s_wb_dat_o = WB_DAT_WIDTH'(frame_count);
      s_wb_adr_i == WB_ADR_WIDTH'(ADR_PARAM_TH):
        s_wb_dat_o = WB_DAT_WIDTH'(param_th);
      s_wb_adr_i == WB_ADR_WIDTH'(ADR_ERR_COUNT):
        s_wb_dat_o = WB_DAT_WIDTH'(err_count);
      default: begin
        for (int k = 0; k < NUM_CLASS; k++)
          if (s_wb_adr_i == WB_ADR_WIDTH'(ADR_RESULT + k))
            s_wb_dat_o = WB_DAT_WIDTH'(result[k]);
      end
    endcase
  end

endmodule

// File: tb/tb_video_mnist_seg_hist.sv
// Directed bench for video_mnist_seg_hist.
// Vector tables plus hand-written multi-cycle sequences.
module tb_video_mnist_seg_hist;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        s_tuser = 0, s_tlast = 0, s_tvalid = 0;
  logic [3:0]  s_tnumber = 0, s_tcount = 0;
  logic        s_tready;
  logic        m_tuser, m_tlast, m_tvalid;
  logic [3:0]  m_tnumber, m_tcount;
  logic        m_tready = 1'b1;
  logic [7:0]  adr = 0;
  logic [31:0] dat_i = 0, dat_o;
  logic        we = 0, stb = 0, ack;
  logic [3:0]  sel = 0;
  logic        irq;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  video_mnist_seg_hist dut (
    .clk             (clk),
    .wb_rst_i        (wb_rst_i),
    .s_axi4s_tuser   (s_tuser),
    .s_axi4s_tlast   (s_tlast),
    .s_axi4s_tnumber (s_tnumber),
    .s_axi4s_tcount  (s_tcount),
    .s_axi4s_tvalid  (s_tvalid),
    .s_axi4s_tready  (s_tready),
    .m_axi4s_tuser   (m_tuser),
    .m_axi4s_tlast   (m_tlast),
    .m_axi4s_tnumber (m_tnumber),
    .m_axi4s_tcount  (m_tcount),
    .m_axi4s_tvalid  (m_tvalid),
    .m_axi4s_tready  (m_tready),
    .s_wb_adr_i      (adr),
    .s_wb_dat_i      (dat_i),
    .s_wb_dat_o      (dat_o),
    .s_wb_we_i       (we),
    .s_wb_sel_i      (sel),
    .s_wb_stb_i      (stb),
    .s_wb_ack_o      (ack),
    .irq             (irq)
  );

  typedef struct {
    logic       tuser;
    logic       tlast;
    logic [3:0] num;
    logic [3:0] cnt;
  } beat_t;

  typedef struct {
    string       nm;
    logic [7:0]  adr;
    logic [31:0] exp;
  } rd_t;

  typedef struct {
    logic       tuser;
    logic       tlast;
    logic [3:0] num;
    logic [3:0] cnt;
    logic       tvalid;
    logic       mready;
    logic [10:0] exp_m;
    logic        exp_rdy;
  } pt_t;

  beat_t frame [8];
  rd_t   rst_tab [10];
  pt_t   pt_tab [3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a,
                        input logic [31:0] exp);
    @(negedge clk);
    adr = a; we = 0; stb = 1;
    #1;
    chk(nm, dat_o, exp);
    stb = 0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    @(negedge clk);
    adr = a; dat_i = d; sel = s; we = 1; stb = 1;
    @(posedge clk);
    #1;
    we = 0; stb = 0;
  endtask

  task automatic drive(input beat_t b);
    s_tuser = b.tuser; s_tlast = b.tlast;
    s_tnumber = b.num; s_tcount = b.cnt;
    s_tvalid = 1'b1;
  endtask

  task automatic beat(input beat_t b);
    drive(b);
    @(posedge clk);
    #1;
    s_tvalid = 0; s_tuser = 0; s_tlast = 0;
  endtask

  task automatic start_beat();
    beat('{1'b1, 1'b0, 4'd1, 4'd2});
  endtask

  task automatic plain(input logic [3:0] n, input int reps);
    for (int i = 0; i < reps; i++)
      beat('{1'b0, 1'b0, n, 4'd2});
  endtask

  task automatic send_frame(input int stall_at,
                            input logic [31:0] stall_fc);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        drive(frame[i]);
        m_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_tready", {31'b0, s_tready}, 32'd0);
        rd_chk("stall_fc", 8'h06, stall_fc);
        rd_chk("stall_err", 8'h08, 32'd5);
        m_tready = 1'b1;
      end
      beat(frame[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    frame[0] = '{1'b1, 1'b0, 4'd3,  4'd2};
    frame[1] = '{1'b0, 1'b0, 4'd3,  4'd2};
    frame[2] = '{1'b0, 1'b0, 4'd3,  4'd2};
    frame[3] = '{1'b0, 1'b1, 4'd0,  4'd2};
    frame[4] = '{1'b0, 1'b0, 4'd0,  4'd2};
    frame[5] = '{1'b0, 1'b0, 4'd10, 4'd2};
    frame[6] = '{1'b0, 1'b0, 4'd10, 4'd2};
    frame[7] = '{1'b0, 1'b1, 4'd10, 4'd2};

    rst_tab[0] = '{"core_id",  8'h00, 32'h527A5E61};
    rst_tab[1] = '{"ctl",      8'h04, 32'd1};
    rst_tab[2] = '{"status",   8'h05, 32'd0};
    rst_tab[3] = '{"fcount",   8'h06, 32'd0};
    rst_tab[4] = '{"param_th", 8'h07, 32'd1};
    rst_tab[5] = '{"err",      8'h08, 32'd0};
    rst_tab[6] = '{"res0",     8'h10, 32'd0};
    rst_tab[7] = '{"res10",    8'h1A, 32'd0};
    rst_tab[8] = '{"hole01",   8'h01, 32'd0};
    rst_tab[9] = '{"hole1b",   8'h1B, 32'd0};

    pt_tab[0] = '{1, 0, 4'd5, 4'd9, 1, 1, 11'b1_0_0101_1001_1, 1'b1};
    pt_tab[1] = '{0, 1, 4'hA, 4'h3, 1, 0, 11'b0_1_1010_0011_1, 1'b0};
    pt_tab[2] = '{1, 1, 4'hF, 4'hF, 0, 1, 11'b1_1_1111_1111_0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      s_tuser = pt_tab[i].tuser; s_tlast = pt_tab[i].tlast;
      s_tnumber = pt_tab[i].num; s_tcount = pt_tab[i].cnt;
      s_tvalid = pt_tab[i].tvalid; m_tready = pt_tab[i].mready;
      #1;
      chk("pass", {21'b0, m_tuser, m_tlast, m_tnumber, m_tcount,
                   m_tvalid}, {21'b0, pt_tab[i].exp_m});
      chk("tready", {31'b0, s_tready}, {31'b0, pt_tab[i].exp_rdy});
    end
    s_tvalid = 0; s_tuser = 0; s_tlast = 0; m_tready = 1;
    for (int i = 0; i < 10; i++)
      rd_chk(rst_tab[i].nm, rst_tab[i].adr, rst_tab[i].exp);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("ack", {31'b0, ack}, 32'd0);
    @(negedge clk);
    wb_rst_i = 1'b1;

    // frame 1, threshold 1
    send_frame(-1, 0);
    start_beat();
    rd_chk("f1_res3",  8'h13, 32'd3);
    rd_chk("f1_res0",  8'h10, 32'd2);
    rd_chk("f1_res10", 8'h1A, 32'd3);
    rd_chk("f1_res1",  8'h11, 32'd0);
    rd_chk("f1_stat",  8'h05, 32'd3);
    rd_chk("f1_fc",    8'h06, 32'd1);
    chk("f1_irq", {31'b0, irq}, 32'd0);

    // threshold 3 suppresses every beat
    wb_write(8'h05, 32'd0, 4'hF);
    rd_chk("clr_stat", 8'h05, 32'd2);
    wb_write(8'h07, 32'd3, 4'h1);
    wb_write(8'h07, 32'd5, 4'h0);
    rd_chk("sel_th", 8'h07, 32'd3);
    send_frame(-1, 0);
    start_beat();
    rd_chk("th_res3",  8'h13, 32'd0);
    rd_chk("th_res0",  8'h10, 32'd0);
    rd_chk("th_res10", 8'h1A, 32'd0);
    rd_chk("th_res1",  8'h11, 32'd0);
    rd_chk("th_stat",  8'h05, 32'd3);
    rd_chk("th_fc",    8'h06, 32'd3);

    // out-of-range classes
    wb_write(8'h07, 32'd1, 4'h1);
    plain(4'd15, 5);
    rd_chk("err5",     8'h08, 32'd5);
    rd_chk("err_res3", 8'h13, 32'd0);
    rd_chk("err_fc",   8'h06, 32'd3);

    // stalled frame must match the unstalled one
    send_frame(4, 4);
    start_beat();
    rd_chk("st_res3",  8'h13, 32'd3);
    rd_chk("st_res0",  8'h10, 32'd2);
    rd_chk("st_res10", 8'h1A, 32'd3);
    rd_chk("st_fc",    8'h06, 32'd5);
    rd_chk("st_err",   8'h08, 32'd5);

    // STATUS clear racing a frame end
    wb_write(8'h04, 32'd3, 4'h1);
    send_frame(-1, 0);
    wb_write(8'h05, 32'd0, 4'hF);
    @(posedge clk);
    #1;
    chk("pre_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    adr = 8'h05; dat_i = 0; sel = 4'hF; we = 1; stb = 1;
    drive('{1'b1, 1'b0, 4'd1, 4'd2});
    @(posedge clk);
    #1;
    we = 0; stb = 0; s_tvalid = 0; s_tuser = 0;
    chk("race_irq0", {31'b0, irq}, 32'd0);
    rd_chk("race_stat", 8'h05, 32'd3);
    @(posedge clk);
    #1;
    chk("race_irq1", {31'b0, irq}, 32'd1);
    rd_chk("race_fc",   8'h06, 32'd7);
    rd_chk("race_res3", 8'h13, 32'd3);

    // disable mid-frame, then re-enable
    plain(4'd3, 2);
    plain(4'd0, 1);
    wb_write(8'h04, 32'd2, 4'h1);
    @(posedge clk);
    rd_chk("dis_stat", 8'h05, 32'd1);
    start_beat();
    plain(4'd0, 2);
    rd_chk("dis_fc", 8'h06, 32'd7);
    wb_write(8'h04, 32'd3, 4'h1);
    start_beat();
    rd_chk("re_fc",   8'h06, 32'd7);
    rd_chk("re_res3", 8'h13, 32'd3);
    rd_chk("re_stat", 8'h05, 32'd3);
    plain(4'd0, 4);
    start_beat();
    rd_chk("re2_fc",   8'h06, 32'd8);
    rd_chk("re2_res0", 8'h10, 32'd4);
    rd_chk("re2_res1", 8'h11, 32'd1);
    rd_chk("re2_res3", 8'h13, 32'd0);

    // reset mid-frame discards the partial frame
    plain(4'd0, 1);
    @(negedge clk);
    wb_rst_i = 1'b0;
    rd_chk("mr_fc",   8'h06, 32'd0);
    rd_chk("mr_res0", 8'h10, 32'd0);
    rd_chk("mr_stat", 8'h05, 32'd0);
    rd_chk("mr_ctl",  8'h04, 32'd1);
    @(negedge clk);
    wb_rst_i = 1'b1;
    plain(4'd0, 2);
    start_beat();
    rd_chk("mr_fc0", 8'h06, 32'd0);
    plain(4'd0, 2);
    start_beat();
    rd_chk("mr_fc1",   8'h06, 32'd1);
    rd_chk("mr_res0b", 8'h10, 32'd2);
    rd_chk("mr_res1",  8'h11, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
